axis_ctr_checker: RTL
=====================

Name: axis_ctr_checker

Overview:
- Synthesizable AXI-Stream sink and checker: the receiving end of the src_ctr counter source.
- Sits on the output of a device under test (delay buffers, FIFOs, PFB pass-through paths).
- Consumes beats under optional pseudo-random backpressure, then checks them against the expected natural-order counter sequence.
- Reports error count, first-error record and completion.
- Used in simulation benches and in on-board loopback tests.

Parameters:
- WIDTH, 16, tdata width in bits.
- MAX_CNT, 64, counter modulus; the expected value wraps to 0 after MAX_CNT-1.
- SKIP_BEATS, 64, number of accepted beats at stream start that must carry tdata==0 (zero-fill of the DUT pipeline).
- CHECK_BEATS, 128, number of counter beats checked before completion.
- BACKPRESSURE, "none", "none" means tready is always high while active; "lfsr" means tready is gated by an LFSR bit.
- LFSR_SEED, 16'hACE1, nonzero seed for the backpressure LFSR.
- ERR_WIDTH, 16, width of the error counter.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- s_axis  axis slave  WIDTH  input stream: tdata, tvalid, tready (tready is driven by this block).
- s_axis_tuser  in  1  sideband bit; recorded in the first-error record only.
- en  in  1  start permission; sampled in IDLE.
- done  out  1  check window complete.
- busy  out  1  in PRIME or CHECK.
- err_cnt  out  ERR_WIDTH  mismatches seen; saturates at all-ones.
- beat_cnt  out  32  total accepted beats since reset.
- first_err_vld  out  1  a first-error record has been captured.
- first_err_idx  out  32  beat_cnt value of the first mismatch.
- first_err_exp  out  WIDTH  expected value at the first mismatch.
- first_err_obs  out  WIDTH  observed tdata at the first mismatch.
- first_err_user  out  1  s_axis_tuser at the first mismatch.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port clk, reset port rst.
- Reset values: tready=0, done=0, busy=0, err_cnt=0, beat_cnt=0, all first_err_* outputs=0. LFSR reloads LFSR_SEED. State returns to IDLE.
- Reset asserted mid-operation aborts immediately. No partial results are retained.
- A beat is accepted only on tvalid&tready at a rising clk edge. tvalid without tready is ignored.
- tready is registered, so a change of state takes effect on the next cycle.
- Backpressure:
  - "none": tready=1 in PRIME and CHECK.
  - "lfsr": 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle. tready = LFSR bit0 in PRIME and CHECK.
  - tready=0 in IDLE and DONE.
- State IDLE: leave when en==1 on a clock edge. Go to PRIME if SKIP_BEATS>0, otherwise CHECK. tready rises in the following cycle.
- State PRIME:
  - Each accepted beat must carry tdata==0; any other value is a mismatch with exp=0.
  - After SKIP_BEATS accepted beats, go to CHECK. The transition is taken on the edge accepting the last skip beat.
- State CHECK:
  - exp starts at 0.
  - Each accepted beat compares tdata to exp; exp = (exp==MAX_CNT-1) ? 0 : exp+1, advancing on every accepted beat, match or not.
  - After CHECK_BEATS accepted beats, go to DONE.
- State DONE: done=1, busy=0, tready=0. Held until rst; en is ignored.
- Mismatch:
  - err_cnt increments by 1 and holds at 2^ERR_WIDTH-1.
  - On the first mismatch only: capture idx, exp, obs and user, and set first_err_vld. Later mismatches leave the record unchanged.
- beat_cnt increments on every accepted beat in PRIME and CHECK and wraps at 2^32.
- Outputs are registered. err_cnt and the first-error record update one cycle after the accepting edge. done asserts one cycle after the final accepting edge.
- Width rules:
  - exp is WIDTH bits.
  - MAX_CNT must be ≤ 2^WIDTH; elaboration $fatal otherwise.
  - SKIP_BEATS and CHECK_BEATS must be < 2^32; CHECK_BEATS must be ≥ 1.
- X-propagation: the bench flags tdata===X via an assertion under `ifndef SYNTHESIS. RTL treats X as a mismatch only in simulation.

Decomposition:
- Shared package (alpaca_ospfb_constants_pkg or its test-utility sibling):
  - chk_state_t enum {IDLE, PRIME, CHECK, DONE}.
  - LFSR tap mask constant.
  - Default LFSR seed.
- One sub-module, lfsr_bp: seedable 16-bit LFSR with synchronous reset and an enable. Shared with a future lfsr-throttled src_ctr.

Test Plan:
- Wire src_ctr (MAX_CNT=64) directly, SKIP_BEATS=0, CHECK_BEATS=128, BACKPRESSURE="none" -> done 129 cycles after en, err_cnt=0, first_err_vld=0, beat_cnt=128.
- Source xpm_delaybuf (FIFO_DEPTH=64) from src_ctr with zero-fill, SKIP_BEATS=64, CHECK_BEATS=128 -> err_cnt=0, beat_cnt=192.
- Same path with BACKPRESSURE="lfsr", seed 16'hACE1 -> err_cnt=0, beat_cnt=192. tready is low on at least one cycle and no beat is lost.
- Force tdata to 0x0005 on checked beat 10 (exp 0x000A) -> err_cnt=1, first_err_idx=10, first_err_exp=0x000A, first_err_obs=0x0005. Later beats still match because exp is not resynced.
- Constant tdata=0xFFFF with ERR_WIDTH=4, CHECK_BEATS=32 -> err_cnt saturates at 15, first_err_idx=0.
- Assert rst at beat 50 of CHECK, then rerun -> all outputs return to 0 the next cycle, the second run completes cleanly, done=0 until the second window ends.

Source files
------------

// File: rtl/axis_ctr_checker_pkg.sv
// Shared types and constants for the AXI-Stream counter checker and its
// backpressure LFSR.
package axis_ctr_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_ctr_checker_lfsr_bp.sv
// Seedable 16-bit Fibonacci LFSR used to throttle stream handshakes.
module axis_ctr_checker_lfsr_bp
  import axis_ctr_checker_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_bit
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_bit = r_lfsr[0];

endmodule

// File: rtl/axis_ctr_checker.sv
// AXI-Stream sink that checks a zero-fill prefix followed by a modulo
// counter sequence, reporting error count, first-error record and completion.
module axis_ctr_checker
  import axis_ctr_checker_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned MAX_CNT      = 64,
  parameter int unsigned SKIP_BEATS   = 64,
  parameter int unsigned CHECK_BEATS  = 128,
  parameter              BACKPRESSURE = "none",
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT,
  parameter int unsigned ERR_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tuser,
  input  logic                 en,
  output logic                 done,
  output logic                 busy,
  output logic [ERR_WIDTH-1:0] err_cnt,
  output logic [31:0]          beat_cnt,
  output logic                 first_err_vld,
  output logic [31:0]          first_err_idx,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_obs,
  output logic                 first_err_user
);

  if (64'(MAX_CNT) > (64'd1 << WIDTH) || MAX_CNT < 1) begin : g_bad_max_cnt
    $fatal(1, "axis_ctr_checker: MAX_CNT must lie in 1..2^WIDTH");
  end
  if (CHECK_BEATS < 1) begin : g_bad_check_beats
    $fatal(1, "axis_ctr_checker: CHECK_BEATS must be at least 1");
  end

  localparam bit               USE_LFSR   = (BACKPRESSURE == "lfsr");
  localparam logic [31:0]      LAST_SKIP  = 32'(SKIP_BEATS - 1);
  localparam logic [31:0]      LAST_CHECK = 32'(CHECK_BEATS - 1);
  localparam logic [WIDTH-1:0] EXP_LAST   = WIDTH'(MAX_CNT - 1);

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] exp_step(input logic [WIDTH-1:0] v);
    return (v == EXP_LAST) ? '0 : v + 1'b1;
  endfunction

  chk_state_t       r_state, w_state_nxt;
  logic [31:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_exp, w_exp_nxt, w_exp_cur;
  logic             r_tready, r_done, r_busy;
  logic [ERR_WIDTH-1:0] r_err_cnt;
  logic [31:0]      r_beat_cnt, r_fe_idx;
  logic             r_fe_vld, r_fe_user;
  logic [WIDTH-1:0] r_fe_exp, r_fe_obs;
  logic             w_lfsr_bit, w_bp_ok, w_active, w_active_nxt, w_acc, w_mis;

  axis_ctr_checker_lfsr_bp #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (1'b1),
    .o_bit (w_lfsr_bit)
  );

  assign w_bp_ok      = USE_LFSR ? w_lfsr_bit : 1'b1;
  assign w_active     = (r_state == PRIME) || (r_state == CHECK);
  assign w_active_nxt = (w_state_nxt == PRIME) || (w_state_nxt == CHECK);
  assign w_acc        = s_axis_tvalid && r_tready && w_active;
  assign w_exp_cur    = (r_state == CHECK) ? r_exp : '0;

  // Four-state compare lets an unknown tdata count as a mismatch in simulation
`ifndef SYNTHESIS
  assign w_mis = w_acc && (s_axis_tdata !== w_exp_cur);
`else
  assign w_mis = w_acc && (s_axis_tdata != w_exp_cur);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_exp_nxt   = r_exp;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = (SKIP_BEATS > 0) ? PRIME : CHECK;
          w_cnt_nxt   = '0;
          w_exp_nxt   = '0;
        end
      end
      PRIME: begin
        if (w_acc) begin
          if (r_cnt == LAST_SKIP) begin
            w_state_nxt = CHECK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      CHECK: begin
        if (w_acc) begin
          w_exp_nxt = exp_step(r_exp);
          if (r_cnt == LAST_CHECK) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_exp      <= '0;
      r_tready   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err_cnt  <= '0;
      r_beat_cnt <= '0;
      r_fe_vld   <= 1'b0;
      r_fe_idx   <= '0;
      r_fe_exp   <= '0;
      r_fe_obs   <= '0;
      r_fe_user  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_exp    <= w_exp_nxt;
      r_tready <= w_active_nxt && w_bp_ok;
      r_busy   <= w_active_nxt;
      r_done   <= (w_state_nxt == DONE);
      if (w_acc) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_mis) begin
        r_err_cnt <= sat_inc(r_err_cnt);
        if (!r_fe_vld) begin
          r_fe_vld  <= 1'b1;
          r_fe_idx  <= r_beat_cnt;
          r_fe_exp  <= w_exp_cur;
          r_fe_obs  <= s_axis_tdata;
          r_fe_user <= s_axis_tuser;
        end
      end
    end
  end

  assign s_axis_tready  = r_tready;
  assign done           = r_done;
  assign busy           = r_busy;
  assign err_cnt        = r_err_cnt;
  assign beat_cnt       = r_beat_cnt;
  assign first_err_vld  = r_fe_vld;
  assign first_err_idx  = r_fe_idx;
  assign first_err_exp  = r_fe_exp;
  assign first_err_obs  = r_fe_obs;
  assign first_err_user = r_fe_user;

endmodule
